// File: rtl/rd_pkg.sv
// Shared encodings and parameter limits for the RD test-pattern source.
package rd_pkg;

  typedef enum logic [1:0] {
    RD_MODE_UP    = 2'd0,
    RD_MODE_DOWN  = 2'd1,
    RD_MODE_WALK  = 2'd2,
    RD_MODE_CONST = 2'd3
  } rd_mode_e;

  typedef enum logic {
    RD_ST_IDLE = 1'b0,
    RD_ST_SEND = 1'b1
  } rd_state_e;

  localparam int RD_NCHAN_MIN      = 1;
  localparam int RD_NCHAN_MAX      = 8;
  localparam int RD_WORD_WIDTH_MIN = 4;
  localparam int RD_WORD_WIDTH_MAX = 16;
  localparam int RD_MEM_SIZE_MIN   = 1;
  localparam int RD_MEM_SIZE_MAX   = 4096;

endpackage

// File: rtl/rd_pattern_lane.sv
// One serial lane: word generator, MSB-first shift-out and odd-parity accumulator.
module rd_pattern_lane
  import rd_pkg::*;
#(
  parameter int WORD_WIDTH = 12,
  parameter int WCW        = 12,
  parameter int LANE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  par_slot,
  input  logic                  inj,
  input  rd_mode_e              mode,
  input  logic [WORD_WIDTH-1:0] pattern,
  input  logic [WCW-1:0]        word_idx,
  output logic                  serial
);

  logic [31:0]           sum;
  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] sh_q;
  logic                  par_q;

  always_comb begin
    sum  = 32'(word_idx) + 32'(LANE);
    word = '0;
    case (mode)
      RD_MODE_UP:   word = WORD_WIDTH'(sum);
      RD_MODE_DOWN: word = ~WORD_WIDTH'(sum);
      RD_MODE_WALK: word = WORD_WIDTH'(1) << (sum % 32'(WORD_WIDTH));
      default:      word = pattern ^ WORD_WIDTH'(LANE);
    endcase
  end

  // par_q holds the XOR of the bits already sent; the parity slot sends its complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      par_q  <= 1'b0;
      serial <= 1'b0;
    end else if (clear) begin
      sh_q   <= '0;
      par_q  <= 1'b0;
      serial <= 1'b0;
    end else if (load) begin
      serial <= word[WORD_WIDTH-1];
      sh_q   <= {word[WORD_WIDTH-2:0], 1'b0};
      par_q  <= word[WORD_WIDTH-1];
    end else if (shift) begin
      serial <= sh_q[WORD_WIDTH-1];
      sh_q   <= {sh_q[WORD_WIDTH-2:0], 1'b0};
      par_q  <= par_q ^ sh_q[WORD_WIDTH-1];
    end else if (par_slot) begin
      serial <= ~par_q ^ inj;
    end
  end

endmodule

// File: rtl/rd_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level.
module rd_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/rd_pattern_gen.sv
// Multi-lane RD serial test-pattern source: sync, trigger edge detect, frame FSM, counters.
// Optional lane-0 parity corruption is built when RD_PATGEN_ERRINJ_EN is defined.
module rd_pattern_gen
  import rd_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int WORD_WIDTH = 12,
  parameter int MEM_SIZE   = 2048
) (
  input  logic                  LOCAL_CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  TRIGGER,
  input  logic [1:0]            MODE,
  input  logic [WORD_WIDTH-1:0] PATTERN,
  input  logic                  ERR_INJECT,
  output logic                  ENABLE_XFR,
  output logic [NCHAN-1:0]      SERIAL_OUT,
  output logic                  DONE,
  output rd_state_e             STATE_DBG
);

  localparam int SCW = $clog2(WORD_WIDTH + 1);
  localparam int WCW = $clog2(MEM_SIZE + 1);
  localparam logic [SCW-1:0] SLOT_PAR     = SCW'(WORD_WIDTH);
  localparam logic [SCW-1:0] SLOT_LASTBIT = SCW'(WORD_WIDTH - 1);
  localparam logic [WCW-1:0] WORD_LAST    = WCW'(MEM_SIZE - 1);

  if (NCHAN < RD_NCHAN_MIN || NCHAN > RD_NCHAN_MAX ||
      WORD_WIDTH < RD_WORD_WIDTH_MIN || WORD_WIDTH > RD_WORD_WIDTH_MAX ||
      MEM_SIZE < RD_MEM_SIZE_MIN || MEM_SIZE > RD_MEM_SIZE_MAX) begin : g_param_err
    $error("rd_pattern_gen: parameter out of range");
  end

  rd_state_e             state_q;
  logic [SCW-1:0]        slot_q;
  logic [WCW-1:0]        word_q;
  rd_mode_e              mode_q;
  logic [WORD_WIDTH-1:0] pat_q;
  logic                  en_s, trig_s, trig_d;

  rd_synchronizer u_sync_en   (.clk(LOCAL_CLK), .rst_n(RESET_N), .d(ENABLE),  .q(en_s));
  rd_synchronizer u_sync_trig (.clk(LOCAL_CLK), .rst_n(RESET_N), .d(TRIGGER), .q(trig_s));

  always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
    if (!RESET_N) trig_d <= 1'b0;
    else          trig_d <= trig_s;
  end

  // Lane strobes describe what the lanes present after the coming edge.
  logic                  start, in_send, abort, at_par, last;
  logic                  lane_clear, lane_load, lane_shift, lane_par, inj0;
  rd_mode_e              mode_sel;
  logic [WORD_WIDTH-1:0] pat_sel;
  logic [WCW-1:0]        next_word;

  assign start      = (state_q == RD_ST_IDLE) && trig_s && !trig_d && en_s;
  assign in_send    = (state_q == RD_ST_SEND) && en_s;
  assign abort      = (state_q == RD_ST_SEND) && !en_s;
  assign at_par     = (slot_q == SLOT_PAR);
  assign last       = at_par && (word_q == WORD_LAST);
  assign lane_clear = abort || (in_send && last);
  assign lane_load  = start || (in_send && at_par && !last);
  assign lane_shift = in_send && (slot_q < SLOT_LASTBIT);
  assign lane_par   = in_send && (slot_q == SLOT_LASTBIT);
  assign mode_sel   = start ? rd_mode_e'(MODE) : mode_q;
  assign pat_sel    = start ? PATTERN : pat_q;
  assign next_word  = start ? '0 : word_q + 1'b1;

  always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= RD_ST_IDLE;
      slot_q     <= '0;
      word_q     <= '0;
      mode_q     <= RD_MODE_UP;
      pat_q      <= '0;
      ENABLE_XFR <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        RD_ST_IDLE: begin
          if (start) begin
            state_q    <= RD_ST_SEND;
            slot_q     <= '0;
            word_q     <= '0;
            mode_q     <= rd_mode_e'(MODE);
            pat_q      <= PATTERN;
            ENABLE_XFR <= 1'b1;
          end
        end
        RD_ST_SEND: begin
          if (!en_s) begin
            state_q    <= RD_ST_IDLE;
            slot_q     <= '0;
            word_q     <= '0;
            ENABLE_XFR <= 1'b0;
          end else if (at_par) begin
            slot_q <= '0;
            if (last) begin
              state_q    <= RD_ST_IDLE;
              word_q     <= '0;
              ENABLE_XFR <= 1'b0;
              DONE       <= 1'b1;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        default: state_q <= RD_ST_IDLE;
      endcase
    end
  end

  assign STATE_DBG = state_q;

`ifdef RD_PATGEN_ERRINJ_EN
  // Requests collapse into one flag consumed by the next lane-0 parity slot.
  logic err_flag_q;

  always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
    if (!RESET_N)                            err_flag_q <= 1'b0;
    else if (abort)                          err_flag_q <= 1'b0;
    else if (lane_par && err_flag_q)         err_flag_q <= 1'b0;
    else if (in_send && ERR_INJECT)          err_flag_q <= 1'b1;
  end

  assign inj0 = lane_par && err_flag_q;
`else
  logic err_inject_unused;
  assign err_inject_unused = ERR_INJECT;
  assign inj0 = 1'b0;
`endif

  for (genvar c = 0; c < NCHAN; c++) begin : g_lane
    rd_pattern_lane #(
      .WORD_WIDTH (WORD_WIDTH),
      .WCW        (WCW),
      .LANE       (c)
    ) u_lane (
      .clk      (LOCAL_CLK),
      .rst_n    (RESET_N),
      .clear    (lane_clear),
      .load     (lane_load),
      .shift    (lane_shift),
      .par_slot (lane_par),
      .inj      ((c == 0) ? inj0 : 1'b0),
      .mode     (mode_sel),
      .pattern  (pat_sel),
      .word_idx (next_word),
      .serial   (SERIAL_OUT[c])
    );
  end

endmodule

// File: tb/tb_rd_pattern_gen.sv
// Directed bench for rd_pattern_gen with NCHAN=2, WORD_WIDTH=12, MEM_SIZE=4.
module tb_rd_pattern_gen;
  import rd_pkg::*;

  localparam int NCH = 2;
  localparam int WW  = 12;
  localparam int MS  = 4;
  localparam int FRAME_BITS = MS * (WW + 1);
`ifdef RD_PATGEN_ERRINJ_EN
  localparam int INJ_K = 1;
`else
  localparam int INJ_K = -1;
`endif

  logic          CLK;
  logic          RESET_N, ENABLE, TRIGGER, ERR_INJECT;
  logic [1:0]    MODE;
  logic [WW-1:0] PATTERN;
  logic          ENABLE_XFR, DONE;
  logic [NCH-1:0] SERIAL_OUT;
  rd_state_e     STATE_DBG;

  rd_pattern_gen #(.NCHAN(NCH), .WORD_WIDTH(WW), .MEM_SIZE(MS)) dut (
    .LOCAL_CLK  (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .TRIGGER    (TRIGGER),
    .MODE       (MODE),
    .PATTERN    (PATTERN),
    .ERR_INJECT (ERR_INJECT),
    .ENABLE_XFR (ENABLE_XFR),
    .SERIAL_OUT (SERIAL_OUT),
    .DONE       (DONE),
    .STATE_DBG  (STATE_DBG)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0]         mode;
    logic [WW-1:0]      pattern;
    logic [3:0][WW-1:0] w0;
    logic [3:0][WW-1:0] w1;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  // Frame capture, sampled on the falling edge
  logic [WW-1:0] cap_word[NCH][MS];
  logic          cap_par[NCH][MS];
  int bit_idx, done_cnt, idle_bad, done_bad;

  always @(negedge CLK) begin
    if (ENABLE_XFR) begin
      if (bit_idx < FRAME_BITS) begin
        for (int c = 0; c < NCH; c++) begin
          if ((bit_idx % (WW + 1)) < WW)
            cap_word[c][bit_idx / (WW + 1)][WW - 1 - (bit_idx % (WW + 1))] = SERIAL_OUT[c];
          else
            cap_par[c][bit_idx / (WW + 1)] = SERIAL_OUT[c];
        end
      end
      bit_idx++;
    end else if (SERIAL_OUT != '0) begin
      idle_bad++;
    end
    if (DONE) begin
      done_cnt++;
      if (ENABLE_XFR) done_bad++;
    end
  end

  task automatic mon_clear();
    bit_idx = 0; done_cnt = 0; idle_bad = 0; done_bad = 0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < MS; k++) begin
        cap_word[c][k] = '0;
        cap_par[c][k]  = 1'b0;
      end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [WW-1:0] w);
    return ~^w;
  endfunction

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic run_trigger(input logic [1:0] m, input logic [WW-1:0] p);
    MODE = m;
    PATTERN = p;
    TRIGGER = 1'b1;
    tick(3);
    TRIGGER = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int t;
    t = 0;
    while (bit_idx < n && t < 300) begin
      tick(1);
      t++;
    end
    check($sformatf("wait_bits_%0d", n), 32'(bit_idx >= n), 32'd1);
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    while (!ENABLE_XFR && t < 20) begin tick(1); t++; end
    check("xfr_start", 32'(ENABLE_XFR), 32'd1);
    t = 0;
    while (ENABLE_XFR && t < 200) begin tick(1); t++; end
    check("xfr_end", 32'(ENABLE_XFR), 32'd0);
    tick(3);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int inj_k);
    logic [WW-1:0] ew;
    logic          ep;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < MS; k++) begin
        ew = (c == 0) ? v.w0[k] : v.w1[k];
        ep = odd_par(ew) ^ ((c == 0 && k == inj_k) ? 1'b1 : 1'b0);
        check($sformatf("%s_l%0d_w%0d_data", tag, c, k), 32'(cap_word[c][k]), 32'(ew));
        check($sformatf("%s_l%0d_w%0d_par", tag, c, k), 32'(cap_par[c][k]), 32'(ep));
      end
    check({tag, "_xfr_cycles"}, 32'(bit_idx), 32'(FRAME_BITS));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_align"}, 32'(done_bad), 32'd0);
    check({tag, "_idle_serial"}, 32'(idle_bad), 32'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, pattern: 12'h000,
                w0: {12'h003, 12'h002, 12'h001, 12'h000},
                w1: {12'h004, 12'h003, 12'h002, 12'h001}};
    vecs[1] = '{mode: 2'd1, pattern: 12'h000,
                w0: {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF},
                w1: {12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE}};
    vecs[2] = '{mode: 2'd2, pattern: 12'h000,
                w0: {12'h008, 12'h004, 12'h002, 12'h001},
                w1: {12'h010, 12'h008, 12'h004, 12'h002}};
    vecs[3] = '{mode: 2'd3, pattern: 12'hA5C,
                w0: {12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C},
                w1: {12'hA5D, 12'hA5D, 12'hA5D, 12'hA5D}};
    vecs[4] = '{mode: 2'd3, pattern: 12'h000,
                w0: {12'h000, 12'h000, 12'h000, 12'h000},
                w1: {12'h001, 12'h001, 12'h001, 12'h001}};

    RESET_N = 1'b0; ENABLE = 1'b1; TRIGGER = 1'b0; ERR_INJECT = 1'b0;
    MODE = 2'd0; PATTERN = '0;
    mon_clear();
    tick(3);
    check("rst_xfr", 32'(ENABLE_XFR), 32'd0);
    check("rst_serial", 32'(SERIAL_OUT), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_state", 32'(STATE_DBG), 32'(RD_ST_IDLE));
    RESET_N = 1'b1;
    tick(4);

    // Trigger-to-output latency: outputs appear after the third edge.
    mon_clear();
    MODE = 2'd0;
    TRIGGER = 1'b1;
    tick(2);
    check("lat_xfr_edge1", 32'(ENABLE_XFR), 32'd0);
    tick(1);
    check("lat_xfr_edge2", 32'(ENABLE_XFR), 32'd1);
    check("lat_first_bits", 32'(SERIAL_OUT), 32'd0);
    check("lat_state", 32'(STATE_DBG), 32'(RD_ST_SEND));
    TRIGGER = 1'b0;
    wait_frame();
    check_frame("lat", vecs[0], -1);

    for (int i = 0; i < NV; i++) begin
      mon_clear();
      run_trigger(vecs[i].mode, vecs[i].pattern);
      wait_frame();
      check_frame($sformatf("vec%0d", i), vecs[i], -1);
    end

    // Retrigger plus mode change during word 1 must not disturb the frame.
    mon_clear();
    run_trigger(2'd0, 12'h000);
    wait_bits(16);
    MODE = 2'd1;
    TRIGGER = 1'b1;
    tick(3);
    TRIGGER = 1'b0;
    wait_frame();
    check_frame("retrig", vecs[0], -1);
    tick(10);
    check("retrig_no_second_xfr", 32'(ENABLE_XFR), 32'd0);
    check("retrig_bits_total", 32'(bit_idx), 32'(FRAME_BITS));

    // Abort in word 2.
    mon_clear();
    run_trigger(2'd0, 12'h000);
    wait_bits(30);
    ENABLE = 1'b0;
    tick(2);
    check("abort_xfr_edge1", 32'(ENABLE_XFR), 32'd1);
    tick(1);
    check("abort_xfr_edge2", 32'(ENABLE_XFR), 32'd0);
    check("abort_serial", 32'(SERIAL_OUT), 32'd0);
    check("abort_state", 32'(STATE_DBG), 32'(RD_ST_IDLE));
    tick(20);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle_serial", 32'(idle_bad), 32'd0);
    check("abort_stays_idle", 32'(ENABLE_XFR), 32'd0);
    ENABLE = 1'b1;
    tick(4);

    // Asynchronous reset mid-frame, then a normal frame afterwards.
    mon_clear();
    run_trigger(2'd0, 12'h000);
    wait_bits(20);
    RESET_N = 1'b0;
    #1;
    check("midrst_xfr", 32'(ENABLE_XFR), 32'd0);
    check("midrst_serial", 32'(SERIAL_OUT), 32'd0);
    check("midrst_done", 32'(DONE), 32'd0);
    tick(2);
    RESET_N = 1'b1;
    tick(4);
    mon_clear();
    run_trigger(2'd0, 12'h000);
    wait_frame();
    check_frame("postrst", vecs[0], -1);

    // Two injection requests in word 1 collapse into one corrupted parity slot.
    mon_clear();
    run_trigger(2'd0, 12'h000);
    wait_bits(15);
    ERR_INJECT = 1'b1;
    tick(1);
    ERR_INJECT = 1'b0;
    tick(2);
    ERR_INJECT = 1'b1;
    tick(1);
    ERR_INJECT = 1'b0;
    wait_frame();
    check_frame("errinj", vecs[0], INJ_K);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rd_pattern_gen.md
# rd_pattern_gen

Parametrised multi-channel test-pattern source for the RD serial data link. On a trigger it emits a frame of MEM_SIZE words per channel: each word is WORD_WIDTH bits MSB-first followed by one odd-parity bit, on NCHAN independent serial lanes, with a selectable data pattern. It stands in for the radio detector on the bench and in loopback, driving the same serial inputs as the real RD front end.

## Interface
- NCHAN, 2, serial lanes, 1..8
- WORD_WIDTH, 12, data bits per word, 4..16
- MEM_SIZE, 2048, words per frame per lane, 1..4096
- LOCAL_CLK  in  1  sole clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  async level; low aborts and holds idle
- TRIGGER  in  1  async; rising edge starts a frame
- MODE  in  2  pattern: 0 count-up, 1 count-down, 2 walking-one, 3 constant
- PATTERN  in  WORD_WIDTH  constant word for mode 3
- ERR_INJECT  in  1  request parity corruption (see Configuration)
- ENABLE_XFR  out  1  high while a frame is on the lanes
- SERIAL_OUT  out  NCHAN  one serial bit per lane
- DONE  out  1  one-cycle pulse after a completed frame

## Operation
- ENABLE and TRIGGER each pass through a two-flop synchronizer; TRIGGER is edge-detected after synchronization.
- States:
  - IDLE -> SEND on a synchronized TRIGGER rising edge while synchronized ENABLE is high.
  - SEND -> IDLE after the parity slot of word MEM_SIZE-1, or on synchronized ENABLE low (abort).
- MODE, PATTERN and the channel offsets are latched on entry to SEND. Changes during a frame are ignored.
- A TRIGGER edge during SEND is ignored and is not queued.
- Slot counter runs 0..WORD_WIDTH:
  - Slots 0..WORD_WIDTH-1 carry data bits WORD_WIDTH-1 down to 0.
  - Slot WORD_WIDTH carries parity = NOT(XOR of the word's data bits), i.e. odd parity.
- Word counter runs 0..MEM_SIZE-1 and increments after each parity slot.
- Word k on lane c, modulo 2^WORD_WIDTH:
  - Mode 0: k + c
  - Mode 1: (2^WORD_WIDTH - 1) - c - k
  - Mode 2: 1 << ((k + c) mod WORD_WIDTH)
  - Mode 3: PATTERN XOR c
- Each lane computes its own data and parity; lanes never share a data register.
- Counters wrap naturally with no saturation. Word counter width is clog2(MEM_SIZE+1).
- Abort: all outputs go to 0; there is no DONE and no partial-word completion.
- Reset values: ENABLE_XFR=0, SERIAL_OUT=0, DONE=0, state IDLE, all counters 0.
- SERIAL_OUT is 0 whenever ENABLE_XFR is 0.

## Timing
- All outputs are registered on the LOCAL_CLK rising edge. There is no negedge logic.
- TRIGGER high set up before edge 0 makes ENABLE_XFR and the first data bit (word 0, bit WORD_WIDTH-1) appear after edge 2.
- One bit per cycle per lane.
- ENABLE_XFR stays high for exactly MEM_SIZE*(WORD_WIDTH+1) cycles.
- ENABLE_XFR falls and DONE pulses on the same edge, the one after the last parity slot.
- A new frame may start on the cycle after DONE.
- ENABLE falling before edge 0 forces ENABLE_XFR=0 after edge 2.
- If an abort and the final slot coincide, the abort wins and DONE stays 0.

## Configuration
- RD_PATGEN_ERRINJ_EN defined:
  - An ERR_INJECT high cycle during SEND arms a flag.
  - The next parity slot on lane 0 is inverted, and then the flag clears.
  - Multiple requests before that slot collapse into one.
  - The flag clears on abort or reset.
- RD_PATGEN_ERRINJ_EN undefined: ERR_INJECT is present but ignored, and parity is always correct.

## Structure
- Shared package rd_pkg holds:
  - MODE encodings: RD_MODE_UP, RD_MODE_DOWN, RD_MODE_WALK, RD_MODE_CONST
  - State encoding: RD_ST_IDLE, RD_ST_SEND
  - Width limits for the three parameters
- Sub-module rd_pattern_lane, one instance per channel, contains:
  - Word generator for the latched mode and lane index
  - Shift-out logic
  - Parity accumulator
  - It is driven by the shared slot and word counters.
- Top level holds the synchronizers (existing rd_synchronizer), edge detect, FSM, counters, DONE and error-inject flag.

## Test plan
All scenarios use NCHAN=2, WORD_WIDTH=12, MEM_SIZE=4.
- Reset: assert RESET_N=0 mid-frame -> ENABLE_XFR=0, SERIAL_OUT=2'b00 and DONE=0 immediately. Trigger is accepted after release.
- Mode 0 trigger:
  - Lane 0 carries 0x000 p1, 0x001 p0, 0x002 p0, 0x003 p1.
  - Lane 1 carries 0x001 p0, 0x002 p0, 0x003 p1, 0x004 p0.
  - ENABLE_XFR is high for 52 cycles and DONE pulses once.
- Mode 1: lane 0 word 0 = 0xFFF p1; lane 1 word 0 = 0xFFE p0. Mode 2: lane 0 words 0x001, 0x002, 0x004, 0x008.
- Robustness:
  - TRIGGER re-pulsed and MODE changed during word 1 -> frame is unchanged and there is exactly one DONE.
  - ENABLE dropped in word 2 -> ENABLE_XFR=0 three edges later, no DONE, SERIAL_OUT=0.
- Error injection with RD_PATGEN_ERRINJ_EN, mode 0, ERR_INJECT pulsed in word 1:
  - Lane 0 word 1 parity = 1; lane 1 is unaffected; later words are correct.
  - Without the macro, parity is always correct.
